// File: rtl/ssg_scan_display.sv
// Multiplexed seven-segment driver with an IDLE/SHIFT/DONE binary-to-BCD converter.
// The converter stages its result so the scanned digits only ever change as a whole.
module ssg_scan_display #(
   parameter int unsigned DATA_WIDTH  = 14,
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 131072
) (
   input  logic                  clock_50Mhz,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic                  hex_mode,
   input  logic                  blank_lz,
   input  logic [N_DIGITS-1:0]   dp_mask,
   output logic [7:0]            seg_out,
   output logic [N_DIGITS-1:0]   anode_out,
   output logic                  overflow
);

   function automatic logic [63:0] ipow(input int unsigned b, input int unsigned e);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < e; i++) r = r * 64'(b);
      return r;
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b1100000;
         4'hC: g = 7'b0110001;
         4'hD: g = 7'b1000010;
         4'hE: g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      return g;
   endfunction

   localparam int unsigned BW  = 4 * N_DIGITS;
   localparam int unsigned CW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned PSW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [63:0] DEC_LIM = ipow(10, N_DIGITS);
   localparam logic [63:0] HEX_LIM = ipow(16, N_DIGITS);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(DATA_WIDTH - 1);
   localparam logic [PW-1:0]  PRESC_TC  = PW'(REFRESH_DIV - 1);
   localparam logic [PSW-1:0] POS_TOP   = PSW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] ANODE_RST = ~(N_DIGITS'(1) << POS_TOP);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         bcd_q, bcd_d;
   logic [DATA_WIDTH-1:0] bin_q, bin_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_stage_q, ovf_stage_d;
   logic                  blank_stage_q, blank_stage_d;
   logic [BW-1:0]         digits_q, digits_d;
   logic                  blank_q, blank_d;
   logic                  ovf_q, ovf_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [PSW-1:0]        pos_q, pos_d;
   logic [7:0]            seg_q, seg_d;
   logic [N_DIGITS-1:0]   anode_q, anode_d;

   logic                       ovf_acc;
   logic [BW-1:0]              hex_val;
   logic [BW-1:0]              adj;
   logic [BW+DATA_WIDTH-1:0]   shifted;
   logic [3:0]                 nib;
   logic                       zero_run;
   logic [N_DIGITS-1:0]        lz;

   // Converter: hex and overflowed values bypass double-dabble and go straight to DONE.
   always_comb begin
      state_d       = state_q;
      bcd_d         = bcd_q;
      bin_d         = bin_q;
      cnt_d         = cnt_q;
      ovf_stage_d   = ovf_stage_q;
      blank_stage_d = blank_stage_q;
      digits_d      = digits_q;
      blank_d       = blank_q;
      ovf_d         = ovf_q;
      nib           = '0;
      adj           = '0;
      ovf_acc = hex_mode ? (64'(data_in) >= HEX_LIM) : (64'(data_in) >= DEC_LIM);
      hex_val = BW'(data_in);
      for (int unsigned j = 0; j < N_DIGITS; j++) begin
         nib = bcd_q[j*4 +: 4];
         adj[j*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
      shifted = {adj, bin_q} << 1;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               ovf_stage_d   = ovf_acc;
               blank_stage_d = blank_lz;
               if (hex_mode || ovf_acc) begin
                  bcd_d   = hex_val;
                  state_d = DONE;
               end else begin
                  bcd_d   = '0;
                  bin_d   = data_in;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            bcd_d = shifted[BW+DATA_WIDTH-1:DATA_WIDTH];
            bin_d = shifted[DATA_WIDTH-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            digits_d = bcd_q;
            blank_d  = blank_stage_q;
            ovf_d    = ovf_stage_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output registers are fed from the next position so anodes move on the scan-step edge.
   always_comb begin
      presc_d  = presc_q + PW'(1);
      pos_d    = pos_q;
      zero_run = 1'b1;
      lz       = '0;
      if (presc_q == PRESC_TC) begin
         presc_d = '0;
         pos_d   = (pos_q == '0) ? POS_TOP : pos_q - PSW'(1);
      end
      for (int unsigned j = 0; j < N_DIGITS; j++) begin
         zero_run = zero_run & (digits_q[(N_DIGITS-1-j)*4 +: 4] == 4'd0);
         lz[N_DIGITS-1-j] = zero_run;
      end
      lz[0] = 1'b0;
      if (ovf_q)
         seg_d[6:0] = 7'b1111110;
      else if (blank_q && lz[pos_d])
         seg_d[6:0] = 7'b1111111;
      else
         seg_d[6:0] = glyph(digits_q[pos_d*4 +: 4]);
      seg_d[7] = ~dp_mask[pos_d];
      anode_d  = ~(N_DIGITS'(1) << pos_d);
   end

   always_ff @(posedge clock_50Mhz) begin
      if (reset) begin
         state_q       <= IDLE;
         bcd_q         <= '0;
         bin_q         <= '0;
         cnt_q         <= '0;
         ovf_stage_q   <= 1'b0;
         blank_stage_q <= 1'b0;
         digits_q      <= '0;
         blank_q       <= 1'b0;
         ovf_q         <= 1'b0;
         presc_q       <= '0;
         pos_q         <= POS_TOP;
         seg_q         <= 8'b1000_0001;
         anode_q       <= ANODE_RST;
      end else begin
         state_q       <= state_d;
         bcd_q         <= bcd_d;
         bin_q         <= bin_d;
         cnt_q         <= cnt_d;
         ovf_stage_q   <= ovf_stage_d;
         blank_stage_q <= blank_stage_d;
         digits_q      <= digits_d;
         blank_q       <= blank_d;
         ovf_q         <= ovf_d;
         presc_q       <= presc_d;
         pos_q         <= pos_d;
         seg_q         <= seg_d;
         anode_q       <= anode_d;
      end
   end

   assign load_ready = (state_q == IDLE);
   assign seg_out    = seg_q;
   assign anode_out  = anode_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ssg_scan_display.sv
// Directed bench for ssg_scan_display: 14-bit input, 4 digits, 4-cycle refresh per digit.
module tb_ssg_scan_display;

   localparam logic [6:0] G0 = 7'b0000001;
   localparam logic [6:0] G1 = 7'b1001111;
   localparam logic [6:0] G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110;
   localparam logic [6:0] G4 = 7'b1001100;
   localparam logic [6:0] G7 = 7'b0001111;
   localparam logic [6:0] GB = 7'b1100000;
   localparam logic [6:0] GE = 7'b0110000;
   localparam logic [6:0] GF = 7'b0111000;
   localparam logic [6:0] DSH = 7'b1111110;
   localparam logic [6:0] BLK = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] data_in;
   logic        load_valid;
   logic        load_ready;
   logic        hex_mode;
   logic        blank_lz;
   logic [3:0]  dp_mask;
   logic [7:0]  seg_out;
   logic [3:0]  anode_out;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ssg_scan_display #(.DATA_WIDTH(14), .N_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clock_50Mhz(clk),
      .reset(reset),
      .data_in(data_in),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .hex_mode(hex_mode),
      .blank_lz(blank_lz),
      .dp_mask(dp_mask),
      .seg_out(seg_out),
      .anode_out(anode_out),
      .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Issues a one-cycle load; returns at the sample point just after the accepting edge.
   task automatic do_load(input logic [13:0] d, input logic hx, input logic bl);
      data_in    = d;
      hex_mode   = hx;
      blank_lz   = bl;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (load_ready) break;
         tick();
      end
      chk(tag, 32'(load_ready), 32'd1);
   endtask

   // Aligns to the first cycle of position 3, then checks one full 16-cycle frame.
   task automatic scan_check(input string tag, input logic [6:0] g3, input logic [6:0] g2,
                             input logic [6:0] g1, input logic [6:0] g0, input logic [3:0] dpm);
      logic [6:0] g [4];
      logic [3:0] prev;
      logic [3:0] ea;
      logic       found;
      int         p;
      g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         prev = anode_out;
         tick();
         if (anode_out == 4'b0111 && prev != 4'b0111) found = 1'b1;
      end
      chk({tag, "_sync"}, 32'(found), 32'd1);
      for (int c = 0; c < 16; c++) begin
         p  = 3 - c / 4;
         ea = ~(4'b0001 << p);
         chk({tag, "_anode"}, 32'(anode_out), 32'(ea));
         chk({tag, "_seg"}, 32'(seg_out), 32'({~dpm[p], g[p]}));
         tick();
      end
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      data_in    = '0;
      hex_mode   = 1'b0;
      blank_lz   = 1'b0;
      dp_mask    = 4'b0000;
      repeat (2) tick();
      chk("rst_ready", 32'(load_ready), 32'd1);
      chk("rst_anode", 32'(anode_out), 32'h7);
      chk("rst_seg", 32'(seg_out), 32'h81);
      chk("rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      scan_check("rst_scan", G0, G0, G0, G0, 4'b0000);

      do_load(14'd10000, 1'b0, 1'b0);
      chk("ovf_ready_k", 32'(load_ready), 32'd0);
      chk("ovf_flag_k", 32'(overflow), 32'd0);
      tick();
      chk("ovf_flag_k1", 32'(overflow), 32'd1);
      chk("ovf_ready_k1", 32'(load_ready), 32'd1);
      scan_check("ovf_scan", DSH, DSH, DSH, DSH, 4'b0000);

      do_load(14'd1234, 1'b0, 1'b0);
      chk("dec_ready_k", 32'(load_ready), 32'd0);
      chk("dec_hold_k", 32'(overflow), 32'd1);
      for (int i = 1; i <= 14; i++) begin
         tick();
         chk("dec_ready_busy", 32'(load_ready), 32'd0);
         chk("dec_hold_busy", 32'(overflow), 32'd1);
      end
      tick();
      chk("dec_ready_k15", 32'(load_ready), 32'd1);
      chk("dec_ovf_k15", 32'(overflow), 32'd0);
      scan_check("dec_scan", G1, G2, G3, G4, 4'b0000);

      do_load(14'h2BEF, 1'b1, 1'b0);
      chk("hex_ready_k", 32'(load_ready), 32'd0);
      tick();
      chk("hex_ready_k1", 32'(load_ready), 32'd1);
      chk("hex_ovf", 32'(overflow), 32'd0);
      scan_check("hex_scan", G2, GB, GE, GF, 4'b0000);

      do_load(14'd7, 1'b0, 1'b1);
      wait_ready("blk7_ready");
      scan_check("blk7_scan", BLK, BLK, BLK, G7, 4'b0000);
      do_load(14'd0, 1'b0, 1'b1);
      wait_ready("blk0_ready");
      scan_check("blk0_scan", BLK, BLK, BLK, G0, 4'b0000);

      dp_mask = 4'b0100;
      scan_check("dp_scan", BLK, BLK, BLK, G0, 4'b0100);
      dp_mask = 4'b0000;

      do_load(14'd1234, 1'b0, 1'b0);
      for (int i = 1; i <= 14; i++) begin
         if (i == 3) begin
            load_valid = 1'b1;
            data_in    = 14'd5;
            hex_mode   = 1'b1;
         end
         if (i == 5) load_valid = 1'b0;
         tick();
         chk("ign_ready_busy", 32'(load_ready), 32'd0);
      end
      hex_mode = 1'b0;
      tick();
      chk("ign_ready_k15", 32'(load_ready), 32'd1);
      tick();
      chk("ign_ready_after", 32'(load_ready), 32'd1);
      scan_check("ign_scan", G1, G2, G3, G4, 4'b0000);

      do_load(14'd9999, 1'b0, 1'b0);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_ready", 32'(load_ready), 32'd1);
      chk("mid_rst_anode", 32'(anode_out), 32'h7);
      chk("mid_rst_seg", 32'(seg_out), 32'h81);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      reset = 1'b0;
      repeat (20) tick();
      chk("mid_rst_idle", 32'(load_ready), 32'd1);
      scan_check("mid_rst_scan", G0, G0, G0, G0, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
